m_mac_pipe: RTL and testbench



---
 rtl/m_mac_pkg.sv | 15 +
 rtl/m_mac_pipe_reg.sv | 35 +++
 rtl/m_mac_pipe.sv | 143 ++++++++++++++
 tb/tb_m_mac_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate unit:
// operation modes and the legal range of the multiplier pipeline depth.
package m_mac_pkg;

    typedef enum logic [1:0] {
        MODE_MADD = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_MUL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int unsigned MUL_STAGES_MIN = 1;
    localparam int unsigned MUL_STAGES_MAX = 4;

endpackage

// File: rtl/m_mac_pipe_reg.sv
// One pipeline stage: a data register plus a valid bit, both advanced by a
// shared enable; only the valid bit is cleared by the synchronous reset.
module m_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/m_mac_pipe.sv
// Stall-all pipelined multiply-accumulate: operand stage, multiplier plus
// MUL_STAGES-1 re-register stages, then an inline add/accumulate stage.
module m_mac_pipe
    import m_mac_pkg::*;
#(
    parameter int unsigned A_W        = 16,
    parameter int unsigned B_W        = 32,
    parameter int unsigned Y_W        = 32,
    parameter int unsigned MUL_STAGES = 1
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    input  logic           w_in_valid,
    output logic           w_in_ready,
    input  logic [1:0]     w_mode,
    input  logic [A_W-1:0] w_a,
    input  logic [B_W-1:0] w_b,
    input  logic [Y_W-1:0] w_c,
    output logic           w_out_valid,
    input  logic           w_out_ready,
    output logic [Y_W-1:0] w_y,
    output logic           w_ovf,
    output logic [Y_W-1:0] w_acc
);

    localparam int unsigned P_W  = A_W + B_W;
    localparam int unsigned S0_W = 2 + A_W + B_W + Y_W;
    localparam int unsigned SM_W = 2 + P_W + Y_W;
    // Wide enough to hold the product and expose at least one bit above Y_W.
    localparam int unsigned X_W  = (P_W > Y_W) ? P_W : Y_W + 1;

    if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_stages
        $error("m_mac_pipe: MUL_STAGES must be within 1..4");
    end

    logic w_en;
    logic r_out_valid;
    logic r_ovf;
    logic [Y_W-1:0] r_y;
    logic [Y_W-1:0] r_acc;

    assign w_en = ~r_out_valid | w_out_ready;

    logic            w_s0_valid;
    logic [S0_W-1:0] w_s0_data;
    logic [1:0]      w_s0_mode;
    logic [A_W-1:0]  w_s0_a;
    logic [B_W-1:0]  w_s0_b;
    logic [Y_W-1:0]  w_s0_c;
    logic [P_W-1:0]  w_prod;

    m_pipe_reg #(.W(S0_W)) u_s0 (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_en    (w_en),
        .i_valid (w_in_valid),
        .i_data  ({w_mode, w_a, w_b, w_c}),
        .o_valid (w_s0_valid),
        .o_data  (w_s0_data)
    );

    assign {w_s0_mode, w_s0_a, w_s0_b, w_s0_c} = w_s0_data;
    assign w_prod = P_W'(w_s0_a) * P_W'(w_s0_b);

    logic [SM_W-1:0] w_st_data  [MUL_STAGES+1];
    logic            w_st_valid [MUL_STAGES+1];

    assign w_st_data[0]  = {w_s0_mode, w_prod, w_s0_c};
    assign w_st_valid[0] = w_s0_valid;

    for (genvar i = 1; i <= MUL_STAGES; i++) begin : g_mul_stage
        m_pipe_reg #(.W(SM_W)) u_st (
            .i_clk   (w_clk),
            .i_rst_n (w_rst_n),
            .i_en    (w_en),
            .i_valid (w_st_valid[i-1]),
            .i_data  (w_st_data[i-1]),
            .o_valid (w_st_valid[i]),
            .o_data  (w_st_data[i])
        );
    end

    logic           w_f_valid;
    logic [1:0]     w_f_mode;
    logic [P_W-1:0] w_f_p;
    logic [Y_W-1:0] w_f_c;
    logic [X_W-1:0] w_p_ext;
    logic [Y_W-1:0] w_pt;
    logic           w_p_hi;
    logic [Y_W:0]   w_sum;
    logic           w_acc_we;
    logic [Y_W-1:0] w_y_d;
    logic           w_ovf_d;

    assign w_f_valid = w_st_valid[MUL_STAGES];
    assign {w_f_mode, w_f_p, w_f_c} = w_st_data[MUL_STAGES];
    assign w_p_ext = X_W'(w_f_p);
    assign w_pt    = w_p_ext[Y_W-1:0];
    assign w_p_hi  = |(w_p_ext >> Y_W);

    always_comb begin
        w_sum    = {1'b0, w_pt};
        w_acc_we = 1'b0;
        case (mode_e'(w_f_mode))
            MODE_MADD: w_sum = {1'b0, w_pt} + {1'b0, w_f_c};
            MODE_ACC: begin
                w_sum    = {1'b0, w_pt} + {1'b0, r_acc};
                w_acc_we = 1'b1;
            end
            MODE_MUL:  w_sum = {1'b0, w_pt};
            MODE_LOAD: w_acc_we = 1'b1;
            default:   w_sum = {1'b0, w_pt};
        endcase
        w_y_d   = w_sum[Y_W-1:0];
        w_ovf_d = w_p_hi | w_sum[Y_W];
    end

    // Result and accumulator hold through stalls and bubbles.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_en) begin
            r_out_valid <= w_f_valid;
            if (w_f_valid) begin
                r_y   <= w_y_d;
                r_ovf <= w_ovf_d;
                if (w_acc_we) begin
                    r_acc <= w_y_d;
                end
            end
        end
    end

    assign w_in_ready  = w_en;
    assign w_out_valid = r_out_valid;
    assign w_y         = r_y;
    assign w_ovf       = r_ovf;
    assign w_acc       = r_acc;

endmodule

// File: tb/tb_m_mac_pipe.sv
// Bench for m_mac_pipe: two instances (MUL_STAGES 1 and 4) share the stimulus;
// results are scored against an arithmetic model of the mode rules.
module tb_m_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c = '0;

    logic        rdy1, rdy4, val1, val4, ovf1, ovf4;
    logic [31:0] y1, y4, acc1, acc4;

    m_mac_pipe #(.A_W(16), .B_W(32), .Y_W(32), .MUL_STAGES(1)) u_dut1 (
        .w_clk(clk), .w_rst_n(rst_n), .w_in_valid(in_valid & ~sel), .w_in_ready(rdy1),
        .w_mode(mode), .w_a(a), .w_b(b), .w_c(c), .w_out_valid(val1),
        .w_out_ready(out_ready | sel), .w_y(y1), .w_ovf(ovf1), .w_acc(acc1)
    );

    m_mac_pipe #(.A_W(16), .B_W(32), .Y_W(32), .MUL_STAGES(4)) u_dut4 (
        .w_clk(clk), .w_rst_n(rst_n), .w_in_valid(in_valid & sel), .w_in_ready(rdy4),
        .w_mode(mode), .w_a(a), .w_b(b), .w_c(c), .w_out_valid(val4),
        .w_out_ready(out_ready | ~sel), .w_y(y4), .w_ovf(ovf4), .w_acc(acc4)
    );

    logic        o_rdy, o_valid, o_ovf;
    logic [31:0] o_y, o_acc;
    assign o_rdy   = sel ? rdy4 : rdy1;
    assign o_valid = sel ? val4 : val1;
    assign o_ovf   = sel ? ovf4 : ovf1;
    assign o_y     = sel ? y4 : y1;
    assign o_acc   = sel ? acc4 : acc1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
        logic [31:0] acc;
        int          cyc;
    } res_t;

    res_t        exp_q[$];
    res_t        obs_q[$];
    logic [31:0] m_acc = '0;

    // Behavioural rules: full product, low word, modular sums, overflow flag.
    function automatic void model(input logic [1:0] md, input logic [15:0] aa,
                                  input logic [31:0] bb, input logic [31:0] cc,
                                  inout logic [31:0] acc, output logic [31:0] y,
                                  output logic ovf);
        logic [63:0] p, pt, s;
        p   = 64'(aa) * 64'(bb);
        pt  = p & 64'h0000_0000_FFFF_FFFF;
        ovf = (p >> 32) != 64'd0;
        if (md == 2'd0)      s = pt + 64'(cc);
        else if (md == 2'd1) s = pt + 64'(acc);
        else                 s = pt;
        if ((s >> 32) != 64'd0) ovf = 1'b1;
        y = s[31:0];
        if (md == 2'd1 || md == 2'd3) acc = y;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        res_t r;
        logic [31:0] ey;
        logic        eovf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                obs_q.delete();
                m_acc = '0;
            end else begin
                if (o_valid && out_ready) begin
                    r.y = o_y; r.ovf = o_ovf; r.acc = o_acc; r.cyc = cyc;
                    obs_q.push_back(r);
                end
                if (in_valid && o_rdy) begin
                    model(mode, a, b, c, m_acc, ey, eovf);
                    r.y = ey; r.ovf = eovf; r.acc = m_acc; r.cyc = cyc;
                    exp_q.push_back(r);
                end
            end
        end
    end

    function automatic int lat();
        return sel ? 6 : 3;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] md, input logic [15:0] aa,
                        input logic [31:0] bb, input logic [31:0] cc);
        int n = 0;
        mode = md; a = aa; b = bb; c = cc; in_valid = 1'b1;
        @(negedge clk);
        while (!o_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_rdy) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", o_rdy, n);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (obs_q.size() < n) begin
            checks++; failures++;
            $display("FAIL result_timeout: got %0d results, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (val1 !== 1'b0 || val4 !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid: got %0b/%0b required 0/0", val1, val4); end
        checks++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready: got %0b/%0b required 1/1", rdy1, rdy4); end
        checks++; if (acc1 !== 32'd0 || acc4 !== 32'd0) begin failures++;
            $display("FAIL reset_acc: got %0h/%0h required 0/0", acc1, acc4); end
        checks++; if (y1 !== 32'd0 || y4 !== 32'd0 || ovf1 !== 1'b0 || ovf4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_y_ovf: got y %0h/%0h ovf %0b/%0b required zeros",
                     y1, y4, ovf1, ovf4); end
    endtask

    task automatic test_madd();
        logic [31:0] want [4] = '{32'd2, 32'd12, 32'd30, 32'd56};
        do_reset();
        for (int i = 0; i < 4; i++) send(2'd0, 16'(2*i+1), 32'(2*i+2), 32'd0);
        wait_results(4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].y !== want[i] || obs_q[i].ovf !== 1'b0) begin failures++;
                $display("FAIL madd_y[%0d] sel=%0b: got %0d ovf %0b required %0d ovf 0",
                         i, sel, obs_q[i].y, obs_q[i].ovf, want[i]); end
            checks++; if (obs_q[i].cyc - exp_q[0].cyc !== lat() + i) begin failures++;
                $display("FAIL madd_timing[%0d] sel=%0b: got %0d cycles required %0d",
                         i, sel, obs_q[i].cyc - exp_q[0].cyc, lat() + i); end
        end
    endtask

    task automatic test_acc_load();
        logic [31:0] want [5] = '{32'd2, 32'd14, 32'd44, 32'd100, 32'd6};
        do_reset();
        for (int i = 0; i < 4; i++) send(2'd1, 16'(2*i+1), 32'(2*i+2), 32'd0);
        send(2'd3, 16'd2, 32'd3, 32'd0);
        wait_results(5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].y !== want[i] || obs_q[i].acc !== want[i]) begin failures++;
                $display("FAIL acc_y[%0d] sel=%0b: got y %0d acc %0d required %0d",
                         i, sel, obs_q[i].y, obs_q[i].acc, want[i]); end
        end
        checks++; if (o_acc !== 32'd6) begin failures++;
            $display("FAIL load_acc sel=%0b: got %0d required 6", sel, o_acc); end
    endtask

    task automatic test_stall();
        int t = 0;
        do_reset();
        send(2'd1, 16'd1, 32'd2, 32'd0);
        send(2'd1, 16'd3, 32'd4, 32'd0);
        out_ready = 1'b0;
        while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_y !== 32'd2 || o_rdy !== 1'b0 || o_acc !== 32'd2) begin
                failures++;
                $display("FAIL stall_hold[%0d] sel=%0b: got v%0b y%0d rdy%0b acc%0d required v1 y2 rdy0 acc2",
                         k, sel, o_valid, o_y, o_rdy, o_acc);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_results(2);
        checks++; if (obs_q.size() !== 2) begin failures++;
            $display("FAIL stall_count sel=%0b: got %0d results required 2", sel, obs_q.size()); end
        if (obs_q.size() >= 2) begin
            checks++; if (obs_q[0].y !== 32'd2 || obs_q[1].y !== 32'd14) begin failures++;
                $display("FAIL stall_resume sel=%0b: got %0d,%0d required 2,14",
                         sel, obs_q[0].y, obs_q[1].y); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(2'd0, 16'd1, 32'hFFFF_FFFF, 32'd1);
        send(2'd2, 16'h10, 32'h1000_0000, 32'd0);
        wait_results(2);
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].y !== 32'd0 || obs_q[i].ovf !== 1'b1) begin failures++;
                $display("FAIL ovf[%0d] sel=%0b: got y %0h ovf %0b required y 0 ovf 1",
                         i, sel, obs_q[i].y, obs_q[i].ovf); end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        out_ready = 1'b0;
        send(2'd1, 16'd1, 32'd1, 32'd0);
        send(2'd1, 16'd2, 32'd2, 32'd0);
        send(2'd1, 16'd3, 32'd3, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < lat(); k++) begin
            @(negedge clk);
            checks++; if (o_valid !== 1'b0) begin failures++;
                $display("FAIL flush_valid[%0d] sel=%0b: got %0b required 0", k, sel, o_valid); end
        end
        checks++; if (o_acc !== 32'd0) begin failures++;
            $display("FAIL flush_acc sel=%0b: got %0d required 0", sel, o_acc); end
        send(2'd1, 16'd4, 32'd5, 32'd0);
        wait_results(1);
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].y !== 32'd20 || obs_q.size() !== 1) begin failures++;
                $display("FAIL flush_next sel=%0b: got y %0d count %0d required 20 count 1",
                         sel, obs_q[0].y, obs_q.size()); end
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [15:0] ra;
                    logic [31:0] rb;
                    ra = 16'($urandom);
                    rb = $urandom;
                    if ($urandom_range(0, 7) == 0) ra = '0;
                    if ($urandom_range(0, 7) == 0) rb = '0;
                    send(2'($urandom_range(0, 3)), ra, rb, $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_results(40);
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++;
            $display("FAIL rand_count sel=%0b: got %0d required %0d", sel, obs_q.size(),
                     exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].ovf !== exp_q[i].ovf ||
                obs_q[i].acc !== exp_q[i].acc) begin
                failures++;
                $display("FAIL rand[%0d] sel=%0b: got y %0h ovf %0b acc %0h required y %0h ovf %0b acc %0h",
                         i, sel, obs_q[i].y, obs_q[i].ovf, obs_q[i].acc,
                         exp_q[i].y, exp_q[i].ovf, exp_q[i].acc);
            end
        end
    endtask

    initial begin
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            test_madd();
            test_acc_load();
            test_stall();
            test_overflow();
            test_reset_inflight();
            test_random();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
